// File: rtl/spi_sched_pkg.sv
// Shared definitions for the multi-channel SPI start scheduler: FSM state
// encoding, default sizing constants and the round-robin search helper.
package spi_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_WAIT_ACK,
    SCHED_BUSY
  } sched_state_t;

  localparam int unsigned DEF_CNT_W       = 12;
  localparam int unsigned DEF_ACK_TIMEOUT = 15;
  localparam int unsigned MAX_CH          = 16;

  // First set bit of req searching upward from last+1, wrapping at n.
  // Returns last when nothing is requested.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] req,
                                          input int unsigned       last,
                                          input int unsigned       n);
    int unsigned pick;
    logic        found;
    logic [3:0]  idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned off = 1; off <= n; off++) begin
      idx = 4'((last + off) % n);
      if (!found && req[idx]) begin
        pick  = int'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/spi_start_scheduler_if.sv
// Start handshake between the scheduler (master) and the SPI engine (slave).
interface spi_start_scheduler_if #(
  parameter int unsigned CH_W = 2
);
  logic            spi_ready;
  logic            spi_start;
  logic [CH_W-1:0] spi_ch;

  modport master (input spi_ready, output spi_start, output spi_ch);
  modport slave  (output spi_ready, input spi_start, input spi_ch);
endinterface

// File: rtl/spi_sched_timer.sv
// One channel: period timer, one-shot latch and pending flag.
// Optional overrun counter when SPI_SCHED_OVERRUN_EN is defined.
module spi_sched_timer
  import spi_sched_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             oneshot,
  input  logic [CNT_W-1:0] period,
  input  logic             grant,
  output logic             pending
`ifdef SPI_SCHED_OVERRUN_EN
  ,
  output logic [7:0]       overrun
`endif
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             fired;
  logic             active;
  logic             hit;

  assign active  = en && (period != '0) && !(oneshot && fired);
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  // The P-th active edge reloads instead of storing P, giving an exact
  // period of P; >= also catches a period lowered below the current count.
  assign hit     = active && (cnt_inc >= {1'b0, period});

  // Timer, one-shot latch and pending flag (expiry wins over grant clear)
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt     <= '0;
      fired   <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (hit || !active) cnt <= '0;
      else                cnt <= cnt_inc[CNT_W-1:0];
      if (hit && oneshot) fired <= 1'b1;
      pending <= (pending & ~grant) | hit;
    end
  end

`ifdef SPI_SCHED_OVERRUN_EN
  // Saturating count of expiries that land on an unserved pending flag
  always_ff @(posedge clk) begin
    if (rst || !en)
      overrun <= '0;
    else if (hit && pending && !grant && (overrun != '1))
      overrun <= overrun + 8'd1;
  end
`endif

endmodule

// File: rtl/spi_start_scheduler.sv
// Multi-channel SPI start scheduler: NUM_CH period timers arbitrated
// round-robin onto one SPI engine with an acknowledge timeout.
// Optional feature macro: SPI_SCHED_OVERRUN_EN (adds overrun_cnt).
module spi_start_scheduler
  import spi_sched_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_start_scheduler_if.master   spi,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       ch_oneshot,
  input  logic [NUM_CH*CNT_W-1:0] ch_period,
  output logic [NUM_CH-1:0]       pending,
  output logic                    ack_err
`ifdef SPI_SCHED_OVERRUN_EN
  ,
  output logic [NUM_CH*8-1:0]     overrun_cnt
`endif
);

  localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W:0] TO_LAST = (TO_W+1)'(ACK_TIMEOUT);

  sched_state_t    state, state_n;
  logic [CH_W-1:0] last, last_n;
  logic [CH_W-1:0] ch_q, ch_n;
  logic [CH_W-1:0] pick_ch;
  logic            start_q, start_n;
  logic            ack_q, ack_n;
  logic [TO_W-1:0] to_cnt, to_n;
  logic [TO_W:0]   to_inc;
  logic [NUM_CH-1:0] grant_vec;

  assign spi.spi_start = start_q;
  assign spi.spi_ch    = ch_q;
  assign ack_err       = ack_q;

  assign pick_ch = CH_W'(rr_pick(MAX_CH'(pending), int'(last), NUM_CH));
  assign to_inc  = {1'b0, to_cnt} + (TO_W+1)'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    spi_sched_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[i]),
      .oneshot (ch_oneshot[i]),
      .period  (ch_period[i*CNT_W +: CNT_W]),
      .grant   (grant_vec[i]),
      .pending (pending[i])
`ifdef SPI_SCHED_OVERRUN_EN
      ,
      .overrun (overrun_cnt[i*8 +: 8])
`endif
    );
  end

  // FSM state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SCHED_IDLE;
      last    <= CH_W'(NUM_CH - 1);
      ch_q    <= '0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      ch_q    <= ch_n;
      start_q <= start_n;
      ack_q   <= ack_n;
      to_cnt  <= to_n;
    end
  end

  // Next-state, grant selection and timeout counting
  always_comb begin
    state_n   = state;
    last_n    = last;
    ch_n      = ch_q;
    start_n   = 1'b0;
    ack_n     = 1'b0;
    to_n      = to_cnt;
    grant_vec = '0;
    unique case (state)
      SCHED_IDLE: begin
        if (spi.spi_ready && (pending != '0)) begin
          start_n            = 1'b1;
          ch_n               = pick_ch;
          last_n             = pick_ch;
          grant_vec[pick_ch] = 1'b1;
          to_n               = '0;
          state_n            = SCHED_WAIT_ACK;
        end
      end
      SCHED_WAIT_ACK: begin
        if (!spi.spi_ready) begin
          state_n = SCHED_BUSY;
        end else if (to_inc == TO_LAST) begin
          ack_n   = 1'b1;
          state_n = SCHED_IDLE;
        end else begin
          to_n = to_inc[TO_W-1:0];
        end
      end
      SCHED_BUSY: begin
        if (spi.spi_ready) state_n = SCHED_IDLE;
      end
      default: state_n = SCHED_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_start_scheduler.sv
// Directed bench for spi_start_scheduler with an SPI-ready model and a
// start/ack_err recorder sampled on the falling edge.
module tb_spi_start_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_en;
  logic [3:0]  ch_oneshot;
  logic [47:0] ch_period;
  logic [3:0]  pending;
  logic        ack_err;
`ifdef SPI_SCHED_OVERRUN_EN
  logic [31:0] overrun_cnt;
`endif

  spi_start_scheduler_if #(.CH_W(2)) spi_if ();

  spi_start_scheduler #(
    .NUM_CH(4), .CNT_W(12), .CH_W(2), .ACK_TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi_if),
    .ch_en      (ch_en),
    .ch_oneshot (ch_oneshot),
    .ch_period  (ch_period),
    .pending    (pending),
    .ack_err    (ack_err)
`ifdef SPI_SCHED_OVERRUN_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int ready_mode = 0;   // 0: drop 5 cycles after start, 1: held high, 2: held low
  int busy = 0;
  int b2b = 0;
  logic prev_start = 1'b0;
  int st_cyc[$];
  int st_ch[$];
  int ae_cyc[$];

  // Recorder and SPI-ready model
  always @(negedge clk) begin
    if (spi_if.spi_start) begin
      st_cyc.push_back(cyc);
      st_ch.push_back(int'(spi_if.spi_ch));
    end
    if (ack_err) ae_cyc.push_back(cyc);
    if (spi_if.spi_start && prev_start) b2b++;
    prev_start = spi_if.spi_start;
    case (ready_mode)
      1: spi_if.spi_ready = 1'b1;
      2: spi_if.spi_ready = 1'b0;
      default: begin
        if (spi_if.spi_start) begin
          spi_if.spi_ready = 1'b0;
          busy = 5;
        end else if (busy > 1) begin
          busy--;
        end else begin
          busy = 0;
          spi_if.spi_ready = 1'b1;
        end
      end
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic clear_log();
    st_cyc.delete();
    st_ch.delete();
    ae_cyc.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ch_en = '0;
    ch_oneshot = '0;
    ch_period = '0;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (spi_if.spi_start !== 1'b0) begin
      $display("FAIL reset_start: got %b, want 0", spi_if.spi_start); miscompares++;
    end
    vectors++;
    if (spi_if.spi_ch !== 2'd0) begin
      $display("FAIL reset_ch: got %0d, want 0", spi_if.spi_ch); miscompares++;
    end
    vectors++;
    if (pending !== 4'b0000) begin
      $display("FAIL reset_pending: got %b, want 0000", pending); miscompares++;
    end
    vectors++;
    if (ack_err !== 1'b0) begin
      $display("FAIL reset_ack_err: got %b, want 0", ack_err); miscompares++;
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_periodic();
    int n;
    ready_mode = 0;
    clear_log();
    n = cyc;
    ch_period[11:0] = 12'd10;
    ch_en = 4'b0001;
    tick(45);
    vectors++;
    if (st_cyc.size() !== 4) begin
      $display("FAIL periodic_count: got %0d, want 4", st_cyc.size()); miscompares++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (st_cyc[i] !== n + 11 + 10 * i || st_ch[i] !== 0) begin
          $display("FAIL periodic_start%0d: got cyc %0d ch %0d, want cyc %0d ch 0",
                   i, st_cyc[i] - n, st_ch[i], 11 + 10 * i);
          miscompares++;
        end
      end
    end
    vectors++;
    if (ae_cyc.size() !== 0) begin
      $display("FAIL periodic_ack_err: got %0d pulses, want 0", ae_cyc.size()); miscompares++;
    end
    ch_en = '0;
    tick(10);
  endtask

  task automatic test_round_robin();
    int n;
    int exp_ch[5] = '{0, 1, 2, 3, 0};
    int exp_cy[5] = '{21, 28, 35, 42, 49};
    apply_reset();
    clear_log();
    b2b = 0;
    n = cyc;
    for (int i = 0; i < 4; i++) ch_period[i*12 +: 12] = 12'd20;
    ch_en = 4'b1111;
    tick(52);
    vectors++;
    if (st_cyc.size() !== 5) begin
      $display("FAIL rr_count: got %0d, want 5", st_cyc.size()); miscompares++;
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (st_cyc[i] !== n + exp_cy[i] || st_ch[i] !== exp_ch[i]) begin
          $display("FAIL rr_grant%0d: got cyc %0d ch %0d, want cyc %0d ch %0d",
                   i, st_cyc[i] - n, st_ch[i], exp_cy[i], exp_ch[i]);
          miscompares++;
        end
      end
    end
    vectors++;
    if (pending !== 4'b0110) begin
      $display("FAIL rr_pending: got %b, want 0110", pending); miscompares++;
    end
    vectors++;
    if (b2b !== 0) begin
      $display("FAIL rr_back_to_back: got %0d, want 0", b2b); miscompares++;
    end
    ch_en = '0;
    tick(10);
  endtask

  task automatic test_oneshot();
    int n;
    int m;
    apply_reset();
    clear_log();
    ch_oneshot = 4'b0100;
    ch_period[24 +: 12] = 12'd7;
    n = cyc;
    ch_en = 4'b0100;
    tick(30);
    vectors++;
    if (st_cyc.size() !== 1) begin
      $display("FAIL oneshot_count: got %0d, want 1", st_cyc.size()); miscompares++;
    end else begin
      vectors++;
      if (st_cyc[0] !== n + 8 || st_ch[0] !== 2) begin
        $display("FAIL oneshot_first: got cyc %0d ch %0d, want cyc 8 ch 2",
                 st_cyc[0] - n, st_ch[0]);
        miscompares++;
      end
    end
    m = cyc;
    ch_en = 4'b0000;
    tick(1);
    ch_en = 4'b0100;
    tick(25);
    vectors++;
    if (st_cyc.size() !== 2) begin
      $display("FAIL oneshot_rearm_count: got %0d, want 2", st_cyc.size()); miscompares++;
    end else begin
      vectors++;
      if (st_cyc[1] !== m + 9 || st_ch[1] !== 2) begin
        $display("FAIL oneshot_rearm: got cyc %0d ch %0d, want cyc 9 ch 2",
                 st_cyc[1] - m, st_ch[1]);
        miscompares++;
      end
    end
    ch_en = '0;
    ch_oneshot = '0;
    tick(10);
  endtask

  task automatic test_ack_timeout();
    int n;
    apply_reset();
    clear_log();
    ready_mode = 1;
    ch_oneshot = 4'b0011;
    ch_period[0 +: 12]  = 12'd5;
    ch_period[12 +: 12] = 12'd5;
    n = cyc;
    ch_en = 4'b0011;
    tick(45);
    vectors++;
    if (ae_cyc.size() !== 2) begin
      $display("FAIL ack_count: got %0d, want 2", ae_cyc.size()); miscompares++;
    end else begin
      vectors++;
      if (ae_cyc[0] !== n + 21 || ae_cyc[1] !== n + 37) begin
        $display("FAIL ack_timing: got %0d,%0d, want 21,37", ae_cyc[0] - n, ae_cyc[1] - n);
        miscompares++;
      end
    end
    vectors++;
    if (st_cyc.size() !== 2) begin
      $display("FAIL ack_start_count: got %0d, want 2", st_cyc.size()); miscompares++;
    end else begin
      vectors++;
      if (st_cyc[1] !== n + 22 || st_ch[1] !== 1 || st_ch[0] !== 0) begin
        $display("FAIL ack_next_grant: got cyc %0d ch %0d/%0d, want cyc 22 ch 0/1",
                 st_cyc[1] - n, st_ch[0], st_ch[1]);
        miscompares++;
      end
    end
    ch_en = '0;
    ch_oneshot = '0;
    ready_mode = 0;
    tick(5);
  endtask

  task automatic test_overrun();
    apply_reset();
    clear_log();
    ready_mode = 2;
    ch_period[12 +: 12] = 12'd4;
    ch_en = 4'b0010;
    tick(12);
    vectors++;
    if (pending !== 4'b0010 || st_cyc.size() !== 0) begin
      $display("FAIL overrun_pending: got %b starts %0d, want 0010 starts 0",
               pending, st_cyc.size());
      miscompares++;
    end
`ifdef SPI_SCHED_OVERRUN_EN
    vectors++;
    if (overrun_cnt !== 32'h0000_0200) begin
      $display("FAIL overrun_cnt: got %h, want 00000200", overrun_cnt); miscompares++;
    end
`endif
    ch_en = '0;
    tick(1);
    vectors++;
    if (pending !== 4'b0000) begin
      $display("FAIL disable_clear: got %b, want 0000", pending); miscompares++;
    end
`ifdef SPI_SCHED_OVERRUN_EN
    vectors++;
    if (overrun_cnt !== 32'h0) begin
      $display("FAIL overrun_clear: got %h, want 0", overrun_cnt); miscompares++;
    end
`endif
    ready_mode = 0;
    tick(3);
  endtask

  task automatic test_reset_busy();
    int r;
    apply_reset();
    clear_log();
    ready_mode = 0;
    ch_period[12 +: 12] = 12'd3;
    ch_en = 4'b0010;
    tick(6);
    vectors++;
    if (st_cyc.size() !== 1 || spi_if.spi_ch !== 2'd1) begin
      $display("FAIL busy_setup: got starts %0d ch %0d, want 1 ch 1",
               st_cyc.size(), spi_if.spi_ch);
      miscompares++;
    end
    rst = 1'b1;
    tick(1);
    vectors++;
    if (spi_if.spi_start !== 1'b0 || spi_if.spi_ch !== 2'd0 ||
        pending !== 4'b0000 || ack_err !== 1'b0) begin
      $display("FAIL busy_reset: got start %b ch %0d pend %b ack %b, want 0 0 0000 0",
               spi_if.spi_start, spi_if.spi_ch, pending, ack_err);
      miscompares++;
    end
    clear_log();
    ch_period = '0;
    ch_period[0 +: 12]  = 12'd3;
    ch_period[36 +: 12] = 12'd3;
    ch_en = 4'b1001;
    rst = 1'b0;
    r = cyc;
    tick(12);
    vectors++;
    if (st_cyc.size() < 2) begin
      $display("FAIL post_reset_count: got %0d, want >=2", st_cyc.size()); miscompares++;
    end else begin
      vectors++;
      if (st_cyc[0] !== r + 4 || st_ch[0] !== 0 || st_cyc[1] !== r + 11 || st_ch[1] !== 3) begin
        $display("FAIL post_reset_grants: got %0d/ch%0d %0d/ch%0d, want 4/ch0 11/ch3",
                 st_cyc[0] - r, st_ch[0], st_cyc[1] - r, st_ch[1]);
        miscompares++;
      end
    end
    vectors++;
    if (b2b !== 0) begin
      $display("FAIL back_to_back: got %0d, want 0", b2b); miscompares++;
    end
    ch_en = '0;
    tick(2);
  endtask

  initial begin
    rst = 1'b1;
    ch_en = '0;
    ch_oneshot = '0;
    ch_period = '0;
    tick(3);
    test_reset();
    test_periodic();
    test_round_robin();
    test_oneshot();
    test_ack_timeout();
    test_overrun();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_start_scheduler.md
# spi_start_scheduler

Multi-channel successor to the single-channel SPI start-pulse generator. Each of `NUM_CH` channels runs its own period timer with a runtime-programmable period and a periodic or one-shot mode. Expired channels are arbitrated round-robin onto one SPI engine through a `spi_ready`/`spi_start` handshake with acknowledge timeout. The block sits between the system control registers and the SPI master, and `spi_ch` drives chip-select selection.

## Interface
- `NUM_CH`, 4: number of channels, 1..16
- `CNT_W`, 12: period timer width
- `CH_W`, `$clog2(NUM_CH)` (minimum 1): channel index width
- `ACK_TIMEOUT`, 15: cycles to wait for `spi_ready` to fall after a start
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  synchronous, active-high reset
- `spi_ready`  in  1  SPI master idle and able to accept a start
- `ch_en`  in  NUM_CH  per-channel enable
- `ch_oneshot`  in  NUM_CH  1 = fire once per enable, 0 = periodic
- `ch_period`  in  NUM_CH*CNT_W  per-channel period in cycles, channel i at bits [i*CNT_W +: CNT_W]
- `spi_start`  out  1  one-cycle start pulse
- `spi_ch`  out  CH_W  granted channel, valid while `spi_start`=1, held until the next grant
- `pending`  out  NUM_CH  expired channels not yet served
- `ack_err`  out  1  one-cycle pulse on acknowledge timeout

## Operation
- **Timer i**
  - Active when `ch_en[i]`=1 and `ch_period[i]`≠0. Period 0 means the channel is disabled.
  - Counts 1..P, then reloads to 0 and sets `pending[i]`.
  - The first expiry comes P cycles after enable is sampled. Later expiries follow every P cycles.
- **One-shot mode**: after the first expiry the timer holds at 0 until `ch_en[i]` is deasserted and reasserted.
- **Disable**: `ch_en[i]`=0 clears timer i and `pending[i]` on the same edge.
- **Period change while counting**: takes effect on the next compare. If the count is already ≥ the new P, the timer expires on the next cycle.
- **FSM states**: IDLE, WAIT_ACK, BUSY.
  - IDLE: when `spi_ready`=1 and `pending`≠0, grant the first pending channel searching from `last+1` modulo NUM_CH. Register `spi_start`=1 and `spi_ch`=grant, clear `pending[grant]`, set `last`=grant, go to WAIT_ACK.
  - WAIT_ACK: `spi_ready`=0 goes to BUSY. After ACK_TIMEOUT cycles with `spi_ready` still 1, pulse `ack_err` and go to IDLE; the grant is not re-queued.
  - BUSY: `spi_ready`=1 goes to IDLE.
- **Expiry coinciding with the grant of the same channel**: set wins, so `pending[i]` stays 1.
- **Reset values**: `spi_start`=0, `spi_ch`=0, `pending`=0, `ack_err`=0, all timers 0, `last`=NUM_CH-1 (so channel 0 wins first), state IDLE.
- **Reset mid-transaction**: returns to IDLE immediately. No pulse is emitted on the reset edge.

## Timing
- `pending[i]` is set on edge k. `spi_start` is high from edge k+1 to edge k+2 if the FSM was IDLE with `spi_ready`=1 at edge k+1.
- `spi_start` is never high two cycles in a row. The minimum spacing between starts is 3 cycles (start, ready low, ready high).
- `ack_err` is high for the cycle after the ACK_TIMEOUT-th sampled `spi_ready`=1 in WAIT_ACK.
- Counter arithmetic is unsigned CNT_W bits. Counters never wrap past P.

## Configuration
- Macro: `SPI_SCHED_OVERRUN_EN`.
- **Defined**:
  - Adds output `overrun_cnt` (NUM_CH*8): per-channel 8-bit counters, saturating at 255.
  - A counter increments when its timer expires while `pending[i]` is already 1 and not being granted on that edge.
  - Cleared by reset or by disabling the channel.
- **Undefined**: the port and its logic are absent. Overruns are silently merged.

## Structure
- Shared package `spi_sched_pkg` holds:
  - the FSM state enum (`SCHED_IDLE`, `SCHED_WAIT_ACK`, `SCHED_BUSY`);
  - the default CNT_W and ACK_TIMEOUT constants;
  - a round-robin search function.
- Sub-module `spi_sched_timer` holds one channel's timer, one-shot latch and pending flag. It is instantiated NUM_CH times with generate. Arbiter and FSM live in the top level.

## Test plan
- Reset, then `ch_en`=0001, `ch_period[0]`=10, periodic, `spi_ready` tied to a model that drops for 5 cycles after a start → `spi_start` every 10 cycles with `spi_ch`=0, no `ack_err`.
- Channels 0..3 all enabled with P=20 simultaneously → grants in order 0,1,2,3, each start ≥3 cycles apart. The next round starts again at 0.
- `ch_oneshot[2]`=1, P=7 → exactly one start for channel 2. Toggling `ch_en[2]` 0→1 yields exactly one more start 7 cycles later.
- `spi_ready` held at 1 after a start, ACK_TIMEOUT=15 → `ack_err` pulses once, FSM returns to IDLE, and the next pending channel is served.
- `spi_ready` held at 0, channel 1 with P=4 for 12 cycles → `pending[1]` stays 1. With the macro defined, `overrun_cnt[1]`=2.
- Assert `rst` while in BUSY → all outputs at reset values the next cycle, and the first post-reset grant goes to channel 0.
